// File: rtl/agc_pkg.sv
// Shared types, default thresholds and the saturating magnitude helper for the AGC level tracker.
package agc_pkg;

   typedef enum logic [1:0] {
      AGC_QUIET  = 2'd0,
      AGC_NORMAL = 2'd1,
      AGC_LOUD   = 2'd2,
      AGC_CLIP   = 2'd3
   } agc_state_e;

   localparam logic [15:0] AGC_TH_NORMAL = 16'd512;
   localparam logic [15:0] AGC_TH_LOUD   = 16'd8192;
   localparam logic [15:0] AGC_TH_CLIP   = 16'd30000;

   // Magnitude of a sign-extended w-bit sample; the most negative code clips to the largest positive one.
   function automatic logic [31:0] agc_sat_abs(input logic signed [31:0] v, input int unsigned w);
      logic [31:0] mag;
      logic [31:0] lim;
      mag = (v < 0) ? 32'(-v) : 32'(v);
      lim = (32'd1 << (w - 1)) - 32'd1;
      return (mag > lim) ? lim : mag;
   endfunction

endpackage

// File: rtl/agc_peak_env.sv
// Peak envelope follower: instant attack to the sample magnitude, shift-based release, advancing only when enabled.
module agc_peak_env
   import agc_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int DECAY_SHIFT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en_i,
   input  logic [DATA_W-1:0] sample_i,
   output logic [DATA_W-1:0] env_o
);

   logic [DATA_W-1:0] env_q;
   logic [DATA_W-1:0] env_d;
   logic [DATA_W-1:0] mag;
   logic signed [31:0] sample_ext;

   always_comb begin
      sample_ext = {{(32-DATA_W){sample_i[DATA_W-1]}}, sample_i};
      mag        = DATA_W'(agc_sat_abs(sample_ext, 32'(DATA_W)));
      env_d      = env_q;
      if (en_i) begin
         // Subtracting a right-shifted copy of itself can never underflow.
         if (mag > env_q) env_d = mag;
         else             env_d = env_q - (env_q >> DECAY_SHIFT);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) env_q <= '0;
      else       env_q <= env_d;
   end

   assign env_o = env_q;

endmodule

// File: rtl/agc_level_state.sv
// 1-deep Avalon-ST pass-through that classifies the peak envelope into a hysteretic 2-bit AGC state.
// Optional sticky clip flag (clip_clear / clip_sticky) is built when AGC_LEVEL_STATE_CLIP_STICKY_EN is defined.
module agc_level_state
   import agc_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int DECAY_SHIFT  = 8,
   parameter int HOLD_SAMPLES = 4800,
   parameter logic [DATA_W-1:0] TH_NORMAL = DATA_W'(AGC_TH_NORMAL),
   parameter logic [DATA_W-1:0] TH_LOUD   = DATA_W'(AGC_TH_LOUD),
   parameter logic [DATA_W-1:0] TH_CLIP   = DATA_W'(AGC_TH_CLIP)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] snk_data,
   input  logic              snk_valid,
   output logic              snk_ready,
   output logic [DATA_W-1:0] src_data,
   output logic              src_valid,
   input  logic              src_ready,
   output logic [1:0]        state,
   output logic [DATA_W-1:0] envelope
`ifdef AGC_LEVEL_STATE_CLIP_STICKY_EN
   ,
   input  logic              clip_clear,
   output logic              clip_sticky
`endif
);

   localparam int CNT_W = $clog2(HOLD_SAMPLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_SAMPLES - 1);

   logic              accept;
   logic [DATA_W-1:0] src_data_q, src_data_d;
   logic              src_valid_q, src_valid_d;
   logic              eval_q;
   logic [DATA_W-1:0] env;
   agc_state_e        target;
   agc_state_e        state_q, state_d;
   logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;

   assign snk_ready = !src_valid_q || src_ready;
   assign accept    = snk_valid && snk_ready;

   always_comb begin
      src_data_d  = src_data_q;
      src_valid_d = src_valid_q;
      if (accept) begin
         src_data_d  = snk_data;
         src_valid_d = 1'b1;
      end else if (src_ready) begin
         src_valid_d = 1'b0;
      end
   end

   agc_peak_env #(
      .DATA_W      (DATA_W),
      .DECAY_SHIFT (DECAY_SHIFT)
   ) u_peak_env (
      .clk      (clk),
      .reset    (reset),
      .en_i     (accept),
      .sample_i (snk_data),
      .env_o    (env)
   );

   always_comb begin
      if      (env >= TH_CLIP)   target = AGC_CLIP;
      else if (env >= TH_LOUD)   target = AGC_LOUD;
      else if (env >= TH_NORMAL) target = AGC_NORMAL;
      else                       target = AGC_QUIET;
   end

   // eval_q marks the cycle right after an accepted sample moved the envelope; only then does the FSM step.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      if (eval_q) begin
         if (target > state_q) begin
            state_d    = target;
            hold_cnt_d = '0;
         end else if (target == state_q) begin
            hold_cnt_d = '0;
         end else if (hold_cnt_q >= CNT_LAST) begin
            state_d    = target;
            hold_cnt_d = '0;
         end else begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_data_q  <= '0;
         src_valid_q <= 1'b0;
         eval_q      <= 1'b0;
         state_q     <= AGC_QUIET;
         hold_cnt_q  <= '0;
      end else begin
         src_data_q  <= src_data_d;
         src_valid_q <= src_valid_d;
         eval_q      <= accept;
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   assign src_data  = src_data_q;
   assign src_valid = src_valid_q;
   assign state     = state_q;
   assign envelope  = env;

`ifdef AGC_LEVEL_STATE_CLIP_STICKY_EN
   logic clip_sticky_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  clip_sticky_q <= 1'b0;
      else if (state_q == AGC_CLIP) clip_sticky_q <= 1'b1;
      else if (clip_clear)        clip_sticky_q <= 1'b0;
   end

   assign clip_sticky = clip_sticky_q;
`endif

endmodule
